spike_index_encoder: RTL and testbench
======================================

// Module: spike_index_encoder
// PURPOSE
//  Sequential set-bit-to-index serialiser for spike/event vectors. Accepts one
//  WIDTH-bit vector per frame and emits the index of every set bit, LSB first,
//  one per cycle, over a valid/ready stream. Per-beat trailing-zero search
//  reuses the Shifter normaliser (oShift = zero count, oData = residual >> count).
//  Sits downstream of spike generation, feeding index-addressed weight fetch.
// PARAMETERS
//  WIDTH  32  vector width; power of two, >= 2
// PORTS
//  iClk    in   1              clock, all state on rising edge
//  iRst    in   1              asynchronous reset, active-high
//  iValid  in   1              input vector valid
//  oReady  out  1              encoder can accept a vector
//  iData   in   WIDTH          spike vector, bit i = event at index i
//  oValid  out  1              oIndex/oLast/oNone valid
//  iReady  in   1              downstream accepts current beat
//  oIndex  out  $clog2(WIDTH)  index of current set bit
//  oLast   out  1              current beat is final beat of frame
//  oNone   out  1              frame had no set bits (single dummy beat)
// BEHAVIOUR
//  - Clocking: one clock iClk. Reset: asynchronous, active-high on iRst.
//  - Reset: state=IDLE, residual R=0, base B=0; oValid=0, oReady=1,
//    oIndex=0, oLast=0, oNone=0. Async assert, release sync to iClk.
//  - States: IDLE (oReady=1, oValid=0), SCAN (oReady=0, oValid=1).
//  - IDLE & iValid: capture R<=iData, B<=0, nz<=|iData; go SCAN.
//    First beat valid the next cycle (1-cycle latency).
//  - SCAN: tz = trailing zeros of R (Shifter oShift on R).
//    oIndex = B + tz; oLast = ((R>>tz)>>1)==0; oNone = ~nz.
//  - Beat accepted (oValid & iReady): R<=(R>>tz)>>1, B<=B+tz+1.
//    B is $clog2(WIDTH)+1 bits internally; oIndex never exceeds WIDTH-1.
//    If oLast, go IDLE. Otherwise stay SCAN.
//  - Zero vector: exactly one beat, oNone=1, oLast=1, oIndex=0.
//  - Stall (oValid & ~iReady): oIndex/oLast/oNone and all state held stable.
//  - iValid while oReady=0 is ignored; upstream holds iData/iValid until the
//    handshake completes.
//  - Throughput: k set bits -> k beats (k>=1), then 1 IDLE cycle before the
//    next vector is accepted. oReady is purely state-decoded, with no
//    combinational path from iReady.
//  - All outputs are decoded from registers plus the tz search on R; no
//    combinational path from iData/iValid to any output.
//  - Reset mid-frame aborts the frame; no further beats are emitted for it.
// TESTING
//  1 Assert iRst mid-clock with no edge -> oValid=0, oReady=1 immediately;
//    hold 3 cycles, release -> still oValid=0, oReady=1.
//  2 WIDTH=8, iData=8'hA4, iReady=1 -> beats oIndex 2,5,7; oLast only on 7;
//    oReady=1 on the cycle after the last beat.
//  3 iData=8'h00 -> exactly one beat: oNone=1, oLast=1, oIndex=0; then IDLE.
//  4 iData=8'hFF, iReady alternating 1,0 -> indices 0..7 in order; each held
//    unchanged during stall cycles; 8 beats total, oLast on 7.
//  5 Single bits: 8'h01 -> one beat idx 0 last; 8'h80 -> one beat idx 7
//    last. WIDTH=32, 32'h8000_0001 -> idx 0 then 31 (last).
//  6 iData=8'hA4, assert iRst after beat idx 2 accepted -> oValid=0 at once;
//    after release, iData=8'h10 -> single beat idx 4 last, no stale idx 5/7.

Source files
------------

// File: rtl/spike_index_encoder.sv
// Serialises the set-bit indices of one WIDTH-bit spike vector, LSB first, one per beat.
// Latency: first beat valid one cycle after the vector handshake; one IDLE cycle between frames.
// Backpressure: a stalled beat holds index/flags and all state; oReady depends only on state.
module spike_index_encoder #(
  parameter int WIDTH = 32,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData,
  output logic             oValid,
  input  logic             iReady,
  output logic [IW-1:0]    oIndex,
  output logic             oLast,
  output logic             oNone
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] r;
  logic [IW:0]      b;
  logic             nz;

  logic [IW-1:0]    tz;
  logic [WIDTH-1:0] norm;
  logic [IW:0]      sum;
  logic             last;
  logic             accept;

  function automatic logic [WIDTH-1:0] low_mask(input int s);
    low_mask = {WIDTH{1'b1}} >> (WIDTH - (1 << s));
  endfunction

  // Logarithmic normaliser: each stage strips 2^s zero LSBs and sets bit s of the count.
  always_comb begin
    norm = r;
    tz   = '0;
    for (int s = IW - 1; s >= 0; s--) begin
      if ((norm & low_mask(s)) == '0) begin
        norm  = norm >> (1 << s);
        tz[s] = 1'b1;
      end
    end
  end

  assign sum  = b + {1'b0, tz};
  assign last = (norm >> 1) == '0;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oReady    = 1'b0;
    oValid    = 1'b0;
    oIndex    = '0;
    oLast     = 1'b0;
    oNone     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        oReady = 1'b1;
        if (iValid) state_nxt = SCAN;
      end
      SCAN: begin
        oValid = 1'b1;
        oNone  = ~nz;
        // An empty frame still emits a single dummy beat at index 0.
        oLast  = ~nz | last;
        oIndex = nz ? sum[IW-1:0] : '0;
        accept = iReady;
        if (iReady && (~nz | last)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r  <= '0;
      b  <= '0;
      nz <= 1'b0;
    end else if (state == IDLE && iValid) begin
      r  <= iData;
      b  <= '0;
      nz <= |iData;
    end else if (accept) begin
      r  <= norm >> 1;
      b  <= sum + (IW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_spike_index_encoder.sv
// Directed bench for spike_index_encoder at WIDTH=8 and WIDTH=32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spike_index_encoder;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        v8, v32;
  logic [7:0]  d8;
  logic [31:0] d32;

  logic        r8, o8_vld, o8_last, o8_none;
  logic [2:0]  o8_idx;
  logic        r32, o32_vld, o32_last, o32_none;
  logic [4:0]  o32_idx;

  int errors = 0;
  int checks = 0;

  spike_index_encoder #(.WIDTH(8)) u_enc8 (
    .iClk(clk), .iRst(rst), .iValid(v8), .oReady(r8), .iData(d8),
    .oValid(o8_vld), .iReady(rdy), .oIndex(o8_idx), .oLast(o8_last), .oNone(o8_none)
  );

  spike_index_encoder #(.WIDTH(32)) u_enc32 (
    .iClk(clk), .iRst(rst), .iValid(v32), .oReady(r32), .iData(d32),
    .oValid(o32_vld), .iReady(rdy), .oIndex(o32_idx), .oLast(o32_last), .oNone(o32_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sends one vector to the selected encoder and checks every beat against the set-bit list.
  task automatic run(input bit w32, input logic [31:0] data, input bit alt);
    int idx[$];
    int n, beats, cyc;
    bit none;
    for (int i = 0; i < (w32 ? 32 : 8); i++)
      if (data[i]) idx.push_back(i);
    none = (idx.size() == 0);
    if (none) idx.push_back(0);
    n = idx.size();

    chk("idle_rdy", w32 ? r32 : r8, 1);
    chk("idle_vld", w32 ? o32_vld : o8_vld, 0);
    if (w32) begin d32 = data; v32 = 1'b1; end
    else     begin d8 = data[7:0]; v8 = 1'b1; end
    rdy = 1'b0;
    @(negedge clk);
    v8 = 1'b0;
    v32 = 1'b0;

    beats = 0;
    cyc = 0;
    while (beats < n && cyc < 200) begin
      chk("beat_vld",  w32 ? o32_vld : o8_vld, 1);
      chk("beat_rdy",  w32 ? r32 : r8, 0);
      chk("beat_idx",  w32 ? 32'(o32_idx) : 32'(o8_idx), idx[beats]);
      chk("beat_last", w32 ? o32_last : o8_last, 32'(beats == n - 1));
      chk("beat_none", w32 ? o32_none : o8_none, 32'(none));
      rdy = alt ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (rdy) beats++;
      cyc++;
    end
    chk("beat_count", beats, n);
    rdy = 1'b0;
    chk("done_vld", w32 ? o32_vld : o8_vld, 0);
    chk("done_rdy", w32 ? r32 : r8, 1);
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b0;
    v8 = 1'b0;
    v32 = 1'b0;
    d8 = '0;
    d32 = '0;

    // Reset asserted between clock edges must act immediately.
    #2 rst = 1'b1;
    #1;
    chk("rst_async_vld8", o8_vld, 0);
    chk("rst_async_rdy8", r8, 1);
    chk("rst_async_vld32", o32_vld, 0);
    chk("rst_async_rdy32", r32, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_vld", o8_vld, 0);
    chk("rst_rel_rdy", r8, 1);
    chk("rst_rel_idx", o8_idx, 0);
    chk("rst_rel_last", o8_last, 0);
    chk("rst_rel_none", o8_none, 0);

    run(1'b0, 32'h0000_00A4, 1'b0);
    run(1'b0, 32'h0000_0000, 1'b0);
    run(1'b0, 32'h0000_00FF, 1'b1);
    run(1'b0, 32'h0000_0001, 1'b0);
    run(1'b0, 32'h0000_0080, 1'b0);
    run(1'b0, 32'h0000_0056, 1'b1);
    run(1'b1, 32'h8000_0001, 1'b0);
    run(1'b1, 32'h0001_0400, 1'b1);
    run(1'b1, 32'h0000_0000, 1'b0);

    // Reset mid-frame: after index 2 is taken, the frame must be dropped.
    chk("abort_idle_rdy", r8, 1);
    d8 = 8'hA4;
    v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    chk("abort_first_idx", o8_idx, 2);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk("abort_second_idx", o8_idx, 5);
    rst = 1'b1;
    #1;
    chk("abort_vld", o8_vld, 0);
    chk("abort_rdy", r8, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_post_vld", o8_vld, 0);
    run(1'b0, 32'h0000_0010, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
